audio_playback_ctrl: RTL and testbench
======================================

# audio_playback_ctrl

Playback sequencer for the PWM audio path. Walks the sample ROM from a programmed start address to an end address, pacing reads with an internal sample-rate tick, and pushes each ROM word into the sound block's sample FIFO through a valid/ready handshake. Supports one-shot and looped playback, graceful stop, and counts underruns (ticks lost because the FIFO did not accept in time). Sits between the top-level controls (buttons/switches) and the ROM + sound datapath.

## Interface

Parameters:
- ADDR_WIDTH, 16: ROM address width.
- DATA_WIDTH, 32: ROM word / FIFO sample width.
- CLK_DIV, 2: clk cycles per sample tick; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle request to begin playback (sampled in IDLE only).
- stop  in  1  single-cycle request to end playback.
- loop_en  in  1  when 1, wrap to start_addr after end_addr; sampled at each end-of-range transfer.
- start_addr  in  ADDR_WIDTH  first sample address; latched on accepted start.
- end_addr  in  ADDR_WIDTH  last sample address (inclusive); latched on accepted start.
- rom_addr  out  ADDR_WIDTH  address to the combinational sample ROM.
- rom_data  in  DATA_WIDTH  ROM word at rom_addr, same cycle.
- smp_data  out  DATA_WIDTH  sample to the FIFO.
- smp_valid  out  1  smp_data valid.
- smp_ready  in  1  FIFO can accept; transfer when smp_valid && smp_ready.
- busy  out  1  1 in RUN or STOPPING.
- done  out  1  one-cycle pulse on return to IDLE from RUN/STOPPING.
- underrun_cnt  out  8  saturating count of dropped ticks since reset.

## Operation

- States: IDLE, RUN, STOPPING.
- IDLE: tick counter held at 0, no pending tick. start && !stop → latch start_addr/end_addr, rom_addr ← start_addr, → RUN. start && stop same cycle → stay IDLE.
- Tick generator (RUN only): counter 0..CLK_DIV-1; tick asserted in the cycle counter == CLK_DIV-1, then counter wraps to 0. First tick occurs CLK_DIV cycles after entering RUN.
- One-deep pending flag `pend`: set by tick, cleared by load. Tick while pend already set → tick dropped, underrun_cnt += 1 (saturates at 255). Load and new tick in same cycle → pend stays set, no underrun.
- Load (RUN, pend && !smp_valid): smp_data ← rom_data, smp_valid ← 1, pend cleared.
- Transfer (smp_valid && smp_ready): smp_valid ← 0 next cycle. If rom_addr == end_addr: loop_en → rom_addr ← start_addr; else → IDLE with done. Otherwise rom_addr ← rom_addr + 1, modulo 2^ADDR_WIDTH (end below start plays through wrap).
- smp_valid, once set, holds with smp_data stable until transfer; never deasserted otherwise.
- stop in RUN: smp_valid == 0 (or transferring this cycle) → IDLE with done; else → STOPPING. pend cleared, no further loads.
- STOPPING: wait for transfer → IDLE with done. Ticks ignored, no underruns counted.
- start while busy ignored; stop in IDLE ignored.
- start_addr == end_addr: single sample, looped or one-shot.

## Timing

- Reset values: rom_addr 0, smp_data 0, smp_valid 0, busy 0, done 0, underrun_cnt 0; state IDLE, tick counter 0, pend 0.
- Start accepted at edge N → busy = 1 and rom_addr = start_addr after edge N.
- Tick in cycle T → pend = 1 after edge T; load at edge T+1 → smp_valid = 1 in cycle T+2 (if no sample outstanding).
- Transfer at edge M → rom_addr advanced and smp_valid = 0 after M; next load no earlier than edge M+1.
- done asserted exactly one cycle, coincident with busy falling; underrun_cnt retained across playbacks, cleared only by rst.
- rst mid-playback: all outputs return to reset values immediately (asynchronous), no done pulse.

## Test plan

- CLK_DIV=4, start_addr=0x10, end_addr=0x13, loop_en=0, smp_ready=1 → 4 samples ROM[0x10..0x13] at 4-cycle spacing, done pulse after 4th transfer, underrun_cnt=0.
- Same, loop_en=1 for 10 samples → address sequence 10,11,12,13,10,11,… then stop → IDLE within 1 cycle of the stop, one done pulse.
- CLK_DIV=2, smp_ready held 0 for 20 cycles after first valid → smp_valid/smp_data stable, pend set, underrun_cnt increments per tick after first: 9; ready=1 → playback resumes with next address.
- smp_ready=0 with valid pending, pulse stop → STOPPING, busy=1; ready=1 → transfer, done, busy=0; no further loads.
- start_addr=0xFFFE, end_addr=0x0001 → addresses FFFE, FFFF, 0000, 0001 then done.
- Assert rst mid-RUN with smp_valid=1 → all outputs 0 immediately; start+stop same cycle in IDLE → remains IDLE, busy=0.

Source files
------------

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer: walks the sample ROM from start_addr to end_addr at the
// sample-tick rate and hands each word to the sound FIFO over valid/ready.
module audio_playback_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            underrun_cnt,
  output logic [1:0]            dbg_state
);

  // Handshake: a sample moves when smp_valid && smp_ready on a rising edge;
  // once raised, smp_valid and smp_data hold unchanged until that transfer.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  localparam int          CW       = 16;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  state_t                  state, state_n;
  logic [CW-1:0]           div_cnt, div_n;
  logic                    pend, pend_n;
  logic [ADDR_WIDTH-1:0]   start_q, start_n;
  logic [ADDR_WIDTH-1:0]   end_q, end_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   data_n;
  logic                    valid_n;
  logic                    done_n;
  logic [7:0]              urun_n;

  logic tick;
  logic xfer;
  logic at_end;
  logic load;

  assign tick   = (state == S_RUN) && (div_cnt == DIV_LAST);
  assign xfer   = smp_valid && smp_ready;
  assign at_end = (rom_addr == end_q);
  assign load   = (state == S_RUN) && !stop && pend && !smp_valid;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      pend         <= 1'b0;
      start_q      <= '0;
      end_q        <= '0;
      rom_addr     <= '0;
      smp_data     <= '0;
      smp_valid    <= 1'b0;
      done         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_n;
      pend         <= pend_n;
      start_q      <= start_n;
      end_q        <= end_n;
      rom_addr     <= addr_n;
      smp_data     <= data_n;
      smp_valid    <= valid_n;
      done         <= done_n;
      underrun_cnt <= urun_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    pend_n  = pend;
    start_n = start_q;
    end_n   = end_q;
    addr_n  = rom_addr;
    data_n  = smp_data;
    valid_n = smp_valid;
    done_n  = 1'b0;
    urun_n  = underrun_cnt;

    // Address advance on every transfer; end of range wraps only when looping.
    if (xfer) begin
      valid_n = 1'b0;
      if (at_end) begin
        if (loop_en) begin
          addr_n = start_q;
        end
      end else begin
        addr_n = rom_addr + ADDR_WIDTH'(1);
      end
    end

    case (state)
      S_IDLE: begin
        div_n  = '0;
        pend_n = 1'b0;
        if (start && !stop) begin
          start_n = start_addr;
          end_n   = end_addr;
          addr_n  = start_addr;
          state_n = S_RUN;
        end
      end

      S_RUN: begin
        div_n = tick ? '0 : div_cnt + CW'(1);
        if (stop) begin
          pend_n = 1'b0;
          div_n  = '0;
          if (!smp_valid || xfer) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_STOPPING;
          end
        end else begin
          // A tick landing on an already-pending slot is lost unless the
          // slot is being consumed in the same cycle.
          if (tick) begin
            pend_n = 1'b1;
            if (pend && !load && (underrun_cnt != 8'hFF)) begin
              urun_n = underrun_cnt + 8'd1;
            end
          end else if (load) begin
            pend_n = 1'b0;
          end
          if (load) begin
            data_n  = rom_data;
            valid_n = 1'b1;
          end
          if (xfer && at_end && !loop_en) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            pend_n  = 1'b0;
            div_n   = '0;
          end
        end
      end

      S_STOPPING: begin
        div_n  = '0;
        pend_n = 1'b0;
        if (xfer) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        div_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Bench for audio_playback_ctrl: directed scenarios plus randomized runs, with
// a scoreboard of expected (address, sample) pairs popped by a monitor.
module tb_audio_playback_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DIV = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] smp_data;
  logic          smp_valid;
  logic          smp_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [7:0]    underrun_cnt;
  logic [1:0]    dbg_state;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [AW-1:0] hi;
    logic [AW-1:0] lo;
    hi = a ^ 16'hA5C3;
    lo = ~a + 16'h1234;
    return {hi, lo};
  endfunction

  assign rom_data = rom_word(rom_addr);

  audio_playback_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .busy(busy), .done(done),
    .underrun_cnt(underrun_cnt), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int last_xfer_edge = -1;
  int first_xfer_edge = -1;
  bit chk_spacing = 1'b0;
  bit rand_mode = 1'b0;
  int exp_ur = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_done = 1'b0;
  logic [AW+DW-1:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: samples on the falling edge, what it sees moves on the next rise
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("valid_hold", smp_valid, 1);
        check("data_hold", smp_data, prev_data);
      end
      if (smp_valid && smp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sample: got addr %0h data %0h expected no transfer", rom_addr, smp_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", {rom_addr, smp_data}, mon_e);
        end
        if (chk_spacing) begin
          if (last_xfer_edge < 0) first_xfer_edge = cyc + 1;
          else check("spacing", cyc + 1 - last_xfer_edge, DIV);
        end
        last_xfer_edge = cyc + 1;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_busy", busy, 0);
        check("done_width", prev_done, 0);
      end
      prev_valid = smp_valid;
      prev_ready = smp_ready;
      prev_data  = smp_data;
      prev_done  = done;
    end
  end

  // randomized ready, never low more than two cycles in a row
  initial begin
    int low_run;
    low_run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        if (low_run >= 2 || $urandom_range(0, 2) != 0) begin
          smp_ready = 1'b1;
          low_run = 0;
        end else begin
          smp_ready = 1'b0;
          low_run++;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int n);
    logic [AW-1:0] a;
    a = sa;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, rom_word(a)});
      a = (a == ea) ? sa : a + 16'd1;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                           input logic lp, output int n_edge);
    start_addr = sa;
    end_addr   = ea;
    loop_en    = lp;
    start      = 1'b1;
    step();
    start  = 1'b0;
    n_edge = cyc;
    check("start_busy", busy, 1);
    check("start_addr", rom_addr, sa);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int k;
    k = 0;
    while (done_cnt == d0 && k < bound) begin
      step();
      k++;
    end
    step();
    check("done_count", done_cnt - d0, 1);
  endtask

  task automatic wait_xfers(input int target, input int bound);
    int k;
    k = 0;
    while (xfer_cnt < target && k < bound) begin
      step();
      k++;
    end
    check("xfer_reached", xfer_cnt >= target, 1);
  endtask

  task automatic wait_valid(input int bound);
    int k;
    k = 0;
    while (!smp_valid && k < bound) begin
      step();
      k++;
    end
    check("valid_seen", smp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_edge;
    int r_edge;
    int d0;
    int x0;
    int len;
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic lp;

    // reset
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_smp_data", smp_data, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun_cnt, 0);

    // one-shot 0x10..0x13 with ready held high
    chk_spacing = 1'b1;
    last_xfer_edge = -1;
    d0 = done_cnt;
    push_seq(16'h0010, 16'h0013, 4);
    start_run(16'h0010, 16'h0013, 1'b0, n_edge);
    wait_done(d0, 100);
    check("first_latency", first_xfer_edge - n_edge, DIV + 2);
    check("oneshot_drained", exp_q.size(), 0);
    check("oneshot_underrun", underrun_cnt, exp_ur);

    // looped 0x10..0x13, stop after ten samples
    last_xfer_edge = -1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    push_seq(16'h0010, 16'h0013, 14);
    start_run(16'h0010, 16'h0013, 1'b1, n_edge);
    wait_xfers(x0 + 10, 200);
    pulse_stop();
    check("loop_stop_busy", busy, 0);
    check("loop_stop_done", done, 1);
    repeat (4) step();
    check("loop_done_once", done_cnt - d0, 1);
    exp_q.delete();

    // underrun: ready low for 20 cycles after the first valid
    chk_spacing = 1'b0;
    smp_ready = 1'b0;
    d0 = done_cnt;
    push_seq(16'h0020, 16'h0027, 8);
    start_run(16'h0020, 16'h0027, 1'b0, n_edge);
    wait_valid(50);
    repeat (20) step();
    check("stall_valid", smp_valid, 1);
    smp_ready = 1'b1;
    r_edge = cyc + 1;
    exp_ur = exp_ur + (r_edge - n_edge) / DIV - 2;
    if (exp_ur > 255) exp_ur = 255;
    wait_done(d0, 200);
    check("stall_underrun", underrun_cnt, exp_ur);
    check("stall_drained", exp_q.size(), 0);

    // graceful stop while a sample is outstanding
    smp_ready = 1'b0;
    d0 = done_cnt;
    push_seq(16'h0030, 16'h0035, 6);
    start_run(16'h0030, 16'h0035, 1'b0, n_edge);
    wait_valid(50);
    pulse_stop();
    check("stopping_busy", busy, 1);
    repeat (12) step();
    check("stopping_still_busy", busy, 1);
    check("stopping_no_done", done_cnt - d0, 0);
    smp_ready = 1'b1;
    wait_done(d0, 20);
    repeat (10) step();
    check("stopped_no_load", smp_valid, 0);
    check("stopped_underrun", underrun_cnt, exp_ur);
    check("stopped_one_sample", exp_q.size(), 5);
    exp_q.delete();

    // address wrap through zero
    chk_spacing = 1'b1;
    last_xfer_edge = -1;
    d0 = done_cnt;
    push_seq(16'hFFFE, 16'h0001, 4);
    start_run(16'hFFFE, 16'h0001, 1'b0, n_edge);
    wait_done(d0, 100);
    check("wrap_drained", exp_q.size(), 0);

    // asynchronous reset mid-run with a sample outstanding
    chk_spacing = 1'b0;
    smp_ready = 1'b0;
    d0 = done_cnt;
    push_seq(16'h0040, 16'h0043, 4);
    start_run(16'h0040, 16'h0043, 1'b0, n_edge);
    wait_valid(50);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", smp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_data", smp_data, 0);
    check("arst_done", done, 0);
    check("arst_underrun", underrun_cnt, 0);
    exp_ur = 0;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    smp_ready = 1'b1;
    step();
    check("arst_no_done", done_cnt - d0, 0);

    // start and stop together in IDLE
    start_addr = 16'h0050;
    end_addr   = 16'h0051;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy, 0);
    repeat (8) step();
    check("startstop_idle", busy, 0);
    check("startstop_no_valid", smp_valid, 0);

    // randomized runs
    rand_mode = 1'b1;
    for (int r = 0; r < 10; r++) begin
      sa  = (r % 3 == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      len = $urandom_range(1, 6);
      ea  = sa + 16'(len - 1);
      lp  = 1'($urandom_range(0, 1));
      d0  = done_cnt;
      x0  = xfer_cnt;
      if (lp) begin
        push_seq(sa, ea, len * 3);
        start_run(sa, ea, 1'b1, n_edge);
        wait_xfers(x0 + len * 2, len * 60);
        pulse_stop();
        wait_done(d0, 40);
        exp_q.delete();
      end else begin
        push_seq(sa, ea, len);
        start_run(sa, ea, 1'b0, n_edge);
        wait_done(d0, len * 30 + 20);
        check("rand_drained", exp_q.size(), 0);
      end
    end
    rand_mode = 1'b0;
    check("final_underrun", underrun_cnt, exp_ur);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
